// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared defines for the EX-stage divider and its sequencing controller.
//   - bus widths (RegBus / DoubleRegBus)
//   - divider handshake constants (DivStart / DivStop / DivResultReady ...)
//   - controller state encoding and the FLUSH cycle count
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  // Divider handshake levels
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Cycles spent in FLUSH with annul asserted. Two cycles are needed because
  // the divider ignores annul while in its divide-by-zero or end state; by the
  // second cycle it has moved to a state that honours it (or is already free).
  localparam logic [1:0] DivFlushCycles = 2'd2;

  typedef enum logic [1:0] {
    DIV_CTRL_IDLE  = 2'b00,
    DIV_CTRL_BUSY  = 2'b01,
    DIV_CTRL_DONE  = 2'b10,
    DIV_CTRL_FLUSH = 2'b11
  } div_ctrl_state_e;

endpackage

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Sequencing controller for the multi-cycle divider in the EX stage.
// Accepts DIV/DIVU from EX, latches the operands, runs the divider's
// start/annul handshake, stalls EX until the 64-bit result returns, then
// presents remainder/quotient as a one-cycle HI/LO write. Pipeline flushes
// annul the divider and park the controller in FLUSH for two cycles so the
// divider always returns to its free state.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   div_req_i           EX holds a valid DIV/DIVU
//   signed_i            1 = DIV, 0 = DIVU
//   op1_i / op2_i       dividend / divisor
//   flush_i             pipeline flush, kills the in-flight divide
//   stall_i             downstream stall, EX cannot advance this cycle
//   div_result_i        from divider: {remainder, quotient}
//   div_ready_i         from divider: result valid
//   div_start_o         to divider: start/hold (0 = stop)
//   div_annul_o         to divider: abort
//   div_signed_o        to divider: latched signed flag
//   div_op1_o/div_op2_o to divider: latched operands
//   stallreq_o          EX stall request (combinational)
//   hilo_we_o           one-cycle HI/LO write enable
//   hi_o / lo_o         remainder / quotient
//
// Handshake: a request is taken when div_req_i is high in IDLE without
// flush_i; EX keeps it held while stallreq_o is high. The result is
// consumed in the DONE cycle in which stall_i and flush_i are both low,
// which is exactly the cycle hilo_we_o is high.
// -----------------------------------------------------------------------------
import div_ctrl_pkg::*;

module div_ctrl (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    div_req_i,
  input  logic                    signed_i,
  input  logic [RegBus-1:0]       op1_i,
  input  logic [RegBus-1:0]       op2_i,
  input  logic                    flush_i,
  input  logic                    stall_i,
  input  logic [DoubleRegBus-1:0] div_result_i,
  input  logic                    div_ready_i,
  output logic                    div_start_o,
  output logic                    div_annul_o,
  output logic                    div_signed_o,
  output logic [RegBus-1:0]       div_op1_o,
  output logic [RegBus-1:0]       div_op2_o,
  output logic                    stallreq_o,
  output logic                    hilo_we_o,
  output logic [RegBus-1:0]       hi_o,
  output logic [RegBus-1:0]       lo_o
);

  div_ctrl_state_e   state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              signed_q, signed_d;
  logic [RegBus-1:0] op1_q, op1_d;
  logic [RegBus-1:0] op2_q, op2_d;
  logic              start_q, start_d;
  logic              annul_q, annul_d;
  logic [RegBus-1:0] hi_q, hi_d;
  logic [RegBus-1:0] lo_q, lo_d;

  // Next-state and datapath capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      DIV_CTRL_IDLE: begin
        // Flush in IDLE simply blocks acceptance; nothing else to undo.
        if (div_req_i && !flush_i) begin
          signed_d = signed_i;
          op1_d    = op1_i;
          op2_d    = op2_i;
          state_d  = DIV_CTRL_BUSY;
        end
      end
      DIV_CTRL_BUSY: begin
        // Operands stay frozen here: the divider re-reads them during its
        // sign fix-up step. Flush wins over a coincident result.
        if (flush_i) begin
          state_d = DIV_CTRL_FLUSH;
        end else if (div_ready_i == DivResultReady) begin
          hi_d    = div_result_i[DoubleRegBus-1:RegBus];
          lo_d    = div_result_i[RegBus-1:0];
          state_d = DIV_CTRL_DONE;
        end
      end
      DIV_CTRL_DONE: begin
        if (flush_i) begin
          state_d = DIV_CTRL_FLUSH;
        end else if (!stall_i) begin
          state_d = DIV_CTRL_IDLE;
        end
      end
      DIV_CTRL_FLUSH: begin
        // Requests are ignored until the count completes.
        if (cnt_q == DivFlushCycles - 2'd1) begin
          cnt_d   = 2'd0;
          state_d = DIV_CTRL_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = DIV_CTRL_IDLE;
    endcase

    if (state_d == DIV_CTRL_FLUSH && state_q != DIV_CTRL_FLUSH) begin
      cnt_d = 2'd0;
    end
  end

  // Handshake outputs are decoded from the next state so they are registered
  // and line up with the state they belong to. Dropping start in DONE is what
  // releases the divider back to free before the next IDLE cycle.
  always_comb begin
    start_d = (state_d == DIV_CTRL_BUSY) ? DivStart : DivStop;
    annul_d = (state_d == DIV_CTRL_FLUSH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DIV_CTRL_IDLE;
      cnt_q    <= 2'd0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      start_q  <= DivStop;
      annul_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      start_q  <= start_d;
      annul_q  <= annul_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Stall request: held for the whole divide, and already in the request
  // cycle so EX does not advance past the DIV.
  always_comb begin
    stallreq_o = 1'b0;
    unique case (state_q)
      DIV_CTRL_IDLE:  stallreq_o = div_req_i & ~flush_i;
      DIV_CTRL_BUSY:  stallreq_o = 1'b1;
      DIV_CTRL_DONE:  stallreq_o = 1'b0;
      DIV_CTRL_FLUSH: stallreq_o = 1'b0;
      default:        stallreq_o = 1'b0;
    endcase
  end

  // The write is qualified by the same-cycle stall/flush so a stalled or
  // flushed DONE cycle never commits; the DONE decode itself is a flop.
  assign hilo_we_o = (state_q == DIV_CTRL_DONE) & ~stall_i & ~flush_i;

  assign div_start_o  = start_q;
  assign div_annul_o  = annul_q;
  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Bench for div_ctrl with a behavioural divider model and a reference
// division function computed in 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_req_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] op1_i = '0;
  logic [31:0] op2_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic        stallreq_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .div_req_i    (div_req_i),
    .signed_i     (signed_i),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .div_signed_o (div_signed_o),
    .div_op1_o    (div_op1_o),
    .div_op2_o    (div_op2_o),
    .stallreq_o   (stallreq_o),
    .hilo_we_o    (hilo_we_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference division ----------------
  // {remainder, quotient}; truncation toward zero, remainder follows the
  // dividend's sign; divide by zero yields {0,0}. 64-bit math avoids the
  // 0x80000000 / -1 overflow.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // ---------------- divider model ----------------
  // Counts the cycles start has been seen high: result ready in the 36th
  // cycle after the request (4th for a zero divisor). Start low or annul
  // returns it to free.
  int dm_cnt;
  bit dm_done;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_cnt       <= 0;
      dm_done      <= 1'b0;
      div_ready_i  <= 1'b0;
      div_result_i <= '0;
    end else begin
      div_ready_i <= 1'b0;
      if (div_annul_o || !div_start_o) begin
        dm_cnt  <= 0;
        dm_done <= 1'b0;
      end else if (!dm_done) begin
        if (dm_cnt + 1 == ((div_op2_o == 32'd0) ? 3 : 35)) begin
          div_ready_i  <= 1'b1;
          div_result_i <= ref_div(div_signed_o, div_op1_o, div_op2_o);
          dm_done      <= 1'b1;
          dm_cnt       <= 0;
        end else begin
          dm_cnt <= dm_cnt + 1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // One full divide starting at the next negedge (cycle 0). Stall is held
  // for stall_n cycles from the expected DONE cycle. Inputs are driven at
  // the negedge, outputs sampled 1 time unit later.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int stall_n, output int sr_cycles, output int we_cycle,
                        output int we_count, output int start_first,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output bit hl_unstable);
    int exp_done;
    logic [63:0] held;
    exp_done    = (b == 32'd0) ? 5 : 37;
    sr_cycles   = 0;
    we_cycle    = -1;
    we_count    = 0;
    start_first = -1;
    hi          = 'x;
    lo          = 'x;
    hl_unstable = 1'b0;
    held        = '0;
    for (int c = 0; c <= exp_done + stall_n + 3; c++) begin
      @(negedge clk);
      div_req_i = (c < exp_done);
      signed_i  = sgn;
      op1_i     = a;
      op2_i     = b;
      flush_i   = 1'b0;
      stall_i   = (c >= exp_done) && (c < exp_done + stall_n);
      #1;
      if (stallreq_o) sr_cycles++;
      if (div_start_o && start_first < 0) start_first = c;
      if (hilo_we_o) begin
        we_count++;
        if (we_cycle < 0) begin
          we_cycle = c;
          hi = hi_o;
          lo = lo_o;
        end
      end
      if (c == exp_done) held = {hi_o, lo_o};
      else if (c > exp_done && c <= exp_done + stall_n && {hi_o, lo_o} !== held)
        hl_unstable = 1'b1;
    end
    div_req_i = 1'b0;
    stall_i   = 1'b0;
  endtask

  // Runs a 100/7 divide and flushes at cycle fc, holding a different request
  // (50/5) during the flush cycles. Returns observations over cycles 0..fc+2.
  task automatic run_flush(input int fc, output int annul_cnt, output int we_cnt,
                           output bit annul_ok, output bit quiet_ok);
    annul_cnt = 0;
    we_cnt    = 0;
    annul_ok  = 1'b1;
    quiet_ok  = 1'b1;
    for (int c = 0; c <= fc + 2; c++) begin
      @(negedge clk);
      div_req_i = 1'b1;
      signed_i  = 1'b0;
      op1_i     = (c <= fc) ? 32'd100 : 32'd50;
      op2_i     = (c <= fc) ? 32'd7 : 32'd5;
      flush_i   = (c == fc);
      stall_i   = 1'b0;
      #1;
      if (div_annul_o) annul_cnt++;
      if (hilo_we_o) we_cnt++;
      if (c > fc && !div_annul_o) annul_ok = 1'b0;
      if (c > fc && (stallreq_o || div_start_o)) quiet_ok = 1'b0;
    end
    flush_i   = 1'b0;
    div_req_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({div_start_o, div_annul_o, div_signed_o, stallreq_o, hilo_we_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {div_start_o, div_annul_o, div_signed_o, stallreq_o, hilo_we_o});
    end
    checks++;
    if ({div_op1_o, div_op2_o, hi_o, lo_o} !== 128'd0) begin
      failures++;
      $display("FAIL reset_data: got op1=%0h op2=%0h hi=%0h lo=%0h expected all 0",
               div_op1_o, div_op2_o, hi_o, lo_o);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_divu_basic();
    int sr, wc, wn, sf;
    logic [31:0] hi, lo;
    bit un;
    do_div(1'b0, 32'd100, 32'd7, 0, sr, wc, wn, sf, hi, lo, un);
    checks++;
    if (sr !== 37) begin failures++; $display("FAIL divu_stallreq_cycles: got %0d expected 37", sr); end
    checks++;
    if (sf !== 1) begin failures++; $display("FAIL divu_start_cycle: got %0d expected 1", sf); end
    checks++;
    if (wc !== 37 || wn !== 1) begin
      failures++; $display("FAIL divu_we: got cycle %0d count %0d expected cycle 37 count 1", wc, wn);
    end
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      failures++; $display("FAIL divu_result: got hi=%0d lo=%0d expected hi=2 lo=14", hi, lo);
    end
  endtask

  task automatic test_signed();
    int sr, wc, wn, sf;
    logic [31:0] hi, lo;
    bit un;
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, sr, wc, wn, sf, hi, lo, un);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD || wc !== 37) begin
      failures++;
      $display("FAIL div_neg7_by_2: got hi=%h lo=%h cycle %0d expected hi=ffffffff lo=fffffffd cycle 37",
               hi, lo, wc);
    end
    do_div(1'b0, 32'hFFFF_FFF9, 32'd2, 0, sr, wc, wn, sf, hi, lo, un);
    checks++;
    if (hi !== 32'd1 || lo !== 32'h7FFF_FFFC) begin
      failures++;
      $display("FAIL divu_fffffff9_by_2: got hi=%h lo=%h expected hi=00000001 lo=7ffffffc", hi, lo);
    end
    checks++;
    if (div_signed_o !== 1'b0) begin
      failures++; $display("FAIL divu_signed_flag: got %b expected 0", div_signed_o);
    end
  endtask

  task automatic test_div_zero();
    int sr, wc, wn, sf;
    logic [31:0] hi, lo;
    bit un;
    do_div(1'b1, 32'd5, 32'd0, 0, sr, wc, wn, sf, hi, lo, un);
    checks++;
    if (wc !== 5 || wn !== 1 || sr !== 5) begin
      failures++;
      $display("FAIL divzero_timing: got we cycle %0d count %0d stallreq %0d expected 5 1 5", wc, wn, sr);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL divzero_result: got hi=%h lo=%h expected 0 0", hi, lo);
    end
  endtask

  task automatic test_flush();
    int an, wn, sr, wc, wn2, sf;
    bit aok, qok, un;
    logic [31:0] hi, lo;
    // flush mid-divide
    run_flush(10, an, wn, aok, qok);
    checks++;
    if (an !== 2 || !aok) begin
      failures++; $display("FAIL flush_busy_annul: got %0d annul cycles ok=%0d expected 2 ok=1", an, aok);
    end
    checks++;
    if (wn !== 0 || !qok) begin
      failures++; $display("FAIL flush_busy_quiet: got we=%0d quiet=%0d expected we=0 quiet=1", wn, qok);
    end
    do_div(1'b0, 32'd9, 32'd3, 0, sr, wc, wn2, sf, hi, lo, un);
    checks++;
    if (sf !== 1 || wc !== 37 || hi !== 32'd0 || lo !== 32'd3) begin
      failures++;
      $display("FAIL flush_then_9_by_3: got start %0d we %0d hi=%0d lo=%0d expected 1 37 0 3", sf, wc, hi, lo);
    end
    // flush in the DONE cycle: write suppressed
    run_flush(37, an, wn, aok, qok);
    checks++;
    if (an !== 2 || !aok || wn !== 0 || !qok) begin
      failures++;
      $display("FAIL flush_done: got annul %0d ok=%0d we=%0d quiet=%0d expected 2 1 0 1", an, aok, wn, qok);
    end
    // flush in IDLE: request not taken
    @(negedge clk);
    div_req_i = 1'b1; op1_i = 32'd8; op2_i = 32'd2; flush_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b0) begin
      failures++; $display("FAIL flush_idle_stallreq: got %b expected 0", stallreq_o);
    end
    @(negedge clk);
    div_req_i = 1'b0; flush_i = 1'b0;
    #1;
    checks++;
    if (div_start_o !== 1'b0 || div_annul_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_noop: got start=%b annul=%b expected 0 0", div_start_o, div_annul_o);
    end
  endtask

  task automatic test_stall_done();
    int sr, wc, wn, sf;
    logic [31:0] hi, lo;
    bit un;
    do_div(1'b0, 32'd100, 32'd7, 3, sr, wc, wn, sf, hi, lo, un);
    checks++;
    if (wc !== 40 || wn !== 1) begin
      failures++; $display("FAIL stall_done_we: got cycle %0d count %0d expected 40 1", wc, wn);
    end
    checks++;
    if (un || hi !== 32'd2 || lo !== 32'd14) begin
      failures++;
      $display("FAIL stall_done_hold: got unstable=%0d hi=%0d lo=%0d expected 0 2 14", un, hi, lo);
    end
    checks++;
    if (sr !== 37) begin failures++; $display("FAIL stall_done_stallreq: got %0d expected 37", sr); end
  endtask

  task automatic test_back_to_back();
    int we_cycles[$];
    logic [63:0] e;
    exp_q.push_back(ref_div(1'b0, 32'd100, 32'd7));
    exp_q.push_back(ref_div(1'b0, 32'd81, 32'd9));
    for (int c = 0; c <= 78; c++) begin
      @(negedge clk);
      div_req_i = (c < 75);
      signed_i  = 1'b0;
      op1_i     = (c < 37) ? 32'd100 : 32'd81;
      op2_i     = (c < 37) ? 32'd7 : 32'd9;
      flush_i   = 1'b0;
      stall_i   = 1'b0;
      #1;
      if (hilo_we_o) begin
        we_cycles.push_back(c);
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_extra_write: got write at cycle %0d expected none", c);
        end else begin
          e = exp_q.pop_front();
          if ({hi_o, lo_o} !== e) begin
            failures++;
            $display("FAIL b2b_result: got hi=%0d lo=%0d expected hi=%0d lo=%0d", hi_o, lo_o, e[63:32], e[31:0]);
          end
        end
      end
    end
    div_req_i = 1'b0;
    checks++;
    if (we_cycles.size() !== 2 || we_cycles[0] !== 37 || we_cycles[1] !== 75) begin
      failures++;
      $display("FAIL b2b_write_cycles: got %0d writes first %0d second %0d expected 2 at 37 and 75",
               we_cycles.size(), (we_cycles.size() > 0) ? we_cycles[0] : -1,
               (we_cycles.size() > 1) ? we_cycles[1] : -1);
    end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    int sr, wc, wn, sf;
    logic [31:0] hi, lo;
    bit un;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      div_req_i = 1'b1; signed_i = 1'b1; op1_i = 32'd1234; op2_i = 32'd11;
    end
    #2 rst = 1'b0;
    div_req_i = 1'b0;
    #1;
    checks++;
    if ({div_start_o, div_signed_o, stallreq_o, hilo_we_o} !== 4'b0 || div_op1_o !== 32'd0 ||
        hi_o !== 32'd2 || lo_o !== 32'd14 || 1'b1) begin
      // hi/lo from the earlier divide must be cleared too
      if ({div_start_o, div_signed_o, stallreq_o, hilo_we_o} !== 4'b0 ||
          {div_op1_o, div_op2_o, hi_o, lo_o} !== 128'd0) begin
        failures++;
        $display("FAIL async_reset_clear: got start=%b sgn=%b op1=%0h hi=%0h lo=%0h expected all 0",
                 div_start_o, div_signed_o, div_op1_o, hi_o, lo_o);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    do_div(1'b1, 32'd1234, 32'd11, 0, sr, wc, wn, sf, hi, lo, un);
    checks++;
    if (wc !== 37 || hi !== 32'd2 || lo !== 32'd112) begin
      failures++;
      $display("FAIL async_reset_recover: got we %0d hi=%0d lo=%0d expected 37 2 112", wc, hi, lo);
    end
  endtask

  task automatic test_random();
    int sr, wc, wn, sf, stall_n;
    logic [31:0] hi, lo, a, b;
    logic sgn;
    bit un;
    logic [63:0] e;
    for (int i = 0; i < 8; i++) begin
      sgn     = 1'($urandom_range(0, 1));
      a       = $urandom;
      b       = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
      stall_n = $urandom_range(0, 2);
      exp_q.push_back(ref_div(sgn, a, b));
      do_div(sgn, a, b, stall_n, sr, wc, wn, sf, hi, lo, un);
      e = exp_q.pop_front();
      checks++;
      if ({hi, lo} !== e) begin
        failures++;
        $display("FAIL rand_result[%0d]: got hi=%h lo=%h expected hi=%h lo=%h (sgn=%0d a=%h b=%h)",
                 i, hi, lo, e[63:32], e[31:0], sgn, a, b);
      end
      checks++;
      if (wc !== ((b == 32'd0) ? 5 : 37) + stall_n || wn !== 1 || un) begin
        failures++;
        $display("FAIL rand_timing[%0d]: got we cycle %0d count %0d unstable %0d expected cycle %0d count 1",
                 i, wc, wn, un, ((b == 32'd0) ? 5 : 37) + stall_n);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_flush();
    test_stall_done();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
